div_hilo_ctrl: RTL and testbench
================================

Name: div_hilo_ctrl

Overview:
- Sequences the shared iterative divider for the pipeline and owns the HI/LO architectural registers.
- Accepts DIV/DIVU, MTHI/MTLO and MFHI/MFLO from the EX stage. Launches the divider with a one-cycle start pulse and stalls EX while a division is in flight.
- Commits quotient to LO and remainder to HI. Discards results when the launching instruction is flushed.
- Sits between the EX stage and the divider instance; the divider itself is unchanged.

Parameters:
- DATA_WIDTH, 32, operand/HI/LO width.
- WDOG_CYCLES, 48, cycles allowed from start pulse to divider complete before the error flag is raised.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- ex_div_req  in  1  DIV/DIVU valid in EX
- ex_div_signed  in  1  1 = DIV, 0 = DIVU
- ex_rs  in  DATA_WIDTH  dividend
- ex_rt  in  DATA_WIDTH  divisor
- ex_mthi  in  1  write HI from ex_rs
- ex_mtlo  in  1  write LO from ex_rs
- ex_mfhilo  in  1  MFHI/MFLO needs HI/LO this cycle
- ex_flush  in  1  exception/flush of the EX-and-older in-flight instruction
- ex_stall  out  1  hold EX
- hi  out  DATA_WIDTH  HI register
- lo  out  DATA_WIDTH  LO register
- div_start  out  1  divider div pulse
- div_signed_o  out  1  divider div_signed
- div_dividend  out  DATA_WIDTH  registered dividend
- div_divisor  out  DATA_WIDTH  registered divisor
- div_busy  in  1  divider busy
- div_complete  in  1  divider complete; quotient/remainder valid only this cycle
- div_quotient  in  DATA_WIDTH  divider quotient
- div_remainder  in  DATA_WIDTH  divider remainder
- wdog_err  out  1  sticky watchdog error

Behaviour:
- Reset (asynchronous, rst=1): state IDLE; hi=lo=0; div_start=0; div_signed_o=0; operand registers 0; ex_stall=0; wdog_err=0; watchdog counter 0.
- FSM states: IDLE, ISSUE, WAIT, DRAIN.
- IDLE, on ex_div_req & !ex_flush & !div_busy:
  - latch ex_rs, ex_rt and ex_div_signed into the operand registers;
  - go to ISSUE;
  - ex_stall=1 combinationally in the same cycle.
- IDLE with div_busy=1 (divider still finishing a drained op): a request is held with ex_stall=1 and not accepted.
- ISSUE: div_start=1 for exactly one cycle, then WAIT. Operands stay stable through ISSUE and WAIT.
- WAIT: ex_stall=1. When div_complete=1:
  - lo<=div_quotient and hi<=div_remainder in the same edge;
  - go to IDLE;
  - ex_stall drops in the next cycle, and new HI/LO are visible then.
- ex_flush in ISSUE or WAIT:
  - the divider cannot abort, so go to DRAIN (ISSUE still issues its pulse);
  - ex_stall deasserts the next cycle.
- DRAIN: ignore results. On div_complete go to IDLE with HI/LO unchanged. A new ex_div_req in DRAIN is stalled until IDLE.
- ex_flush in IDLE together with ex_div_req: the request is ignored.
- MTHI/MTLO:
  - in IDLE or DRAIN, write the next edge;
  - in ISSUE or WAIT, stall (the instruction is younger than the DIV);
  - MTHI and MTLO in the same cycle are both written.
- MFHI/MFLO: ex_stall=1 while state is ISSUE or WAIT; no stall in IDLE or DRAIN.
- Watchdog:
  - the counter clears on div_start and increments in WAIT/DRAIN;
  - when it reaches WDOG_CYCLES, set wdog_err (sticky until rst) and force IDLE with HI/LO unchanged.
- div_complete outside WAIT/DRAIN is ignored.

Optional Feature:
- Macro DIV_ZERO_BYPASS_EN.
- Defined: a request with ex_rt==0 skips the divider entirely (no div_start). The next edge writes lo=all-ones, hi=ex_rs, and ex_stall is asserted for one cycle only.
- Undefined: divide-by-zero is launched normally and the results are whatever the divider produces.

Decomposition:
- Shared package holds:
  - DATA_WIDTH;
  - state encoding constants (IDLE=2'b00, ISSUE=2'b01, WAIT=2'b10, DRAIN=2'b11);
  - the default for WDOG_CYCLES.
- Sub-module: hilo_regfile (HI/LO registers with MT write port and divide-commit write port, commit priority over MT).
- FSM and watchdog stay in div_hilo_ctrl.

Test Plan:
- DIV ex_rs=-7 (0xFFFFFFF9), ex_rt=2 -> one div_start pulse; on complete lo=0xFFFFFFFD, hi=0xFFFFFFFF; ex_stall high from accept until the cycle after complete.
- DIVU 0xFFFFFFFF / 0x10 -> lo=0x0FFFFFFF, hi=0x0000000F; div_signed_o=0 for the whole operation.
- DIV 100/7 with ex_flush asserted 5 cycles after accept -> ex_stall drops the next cycle; after complete hi/lo keep prior values (e.g. 0x11/0x22); a second DIV issued during DRAIN is stalled, then produces lo=0xE, hi=0x2.
- MFLO during WAIT -> stalled until complete+1, then reads the new lo. MTHI 0x1234 in IDLE -> hi=0x1234 the next cycle.
- div_complete tied low -> wdog_err=1 exactly WDOG_CYCLES cycles after div_start; state returns to IDLE; HI/LO unchanged.
- With DIV_ZERO_BYPASS_EN: DIV 5/0 -> no div_start; next cycle lo=0xFFFFFFFF, hi=5; ex_stall high for one cycle only.

Source files
------------

// File: rtl/div_hilo_ctrl_pkg.sv
// Shared constants for the divider sequencer and HI/LO register file.
// State encodings are plain constants so legacy code can compare against them.
package div_hilo_ctrl_pkg;
  localparam int DATA_WIDTH_DEF  = 32;
  localparam int WDOG_CYCLES_DEF = 48;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_ISSUE = 2'b01;
  localparam logic [1:0] ST_WAIT  = 2'b10;
  localparam logic [1:0] ST_DRAIN = 2'b11;
endpackage

// File: rtl/div_hilo_ctrl_hilo_regfile.sv
// HI/LO architectural registers: an MT write port plus a divide-commit port.
// A commit wins over an MT write in the same cycle.
module hilo_regfile #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_mthi,
  input  logic                  i_mtlo,
  input  logic [DATA_WIDTH-1:0] i_mt_data,
  input  logic                  i_cmt_en,
  input  logic [DATA_WIDTH-1:0] i_cmt_hi,
  input  logic [DATA_WIDTH-1:0] i_cmt_lo,
  output logic [DATA_WIDTH-1:0] o_hi,
  output logic [DATA_WIDTH-1:0] o_lo
);
  logic [DATA_WIDTH-1:0] r_hi, r_lo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (i_cmt_en) begin
      r_hi <= i_cmt_hi;
      r_lo <= i_cmt_lo;
    end else begin
      if (i_mthi) r_hi <= i_mt_data;
      if (i_mtlo) r_lo <= i_mt_data;
    end
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;
endmodule

// File: rtl/div_hilo_ctrl.sv
// Sequences the shared iterative divider for EX and owns HI/LO.
// Optional macro DIV_ZERO_BYPASS_EN: divide-by-zero completes locally without the divider.
module div_hilo_ctrl
  import div_hilo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int WDOG_CYCLES = WDOG_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_div_req,
  input  logic                  ex_div_signed,
  input  logic [DATA_WIDTH-1:0] ex_rs,
  input  logic [DATA_WIDTH-1:0] ex_rt,
  input  logic                  ex_mthi,
  input  logic                  ex_mtlo,
  input  logic                  ex_mfhilo,
  input  logic                  ex_flush,
  output logic                  ex_stall,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo,
  output logic                  div_start,
  output logic                  div_signed_o,
  output logic [DATA_WIDTH-1:0] div_dividend,
  output logic [DATA_WIDTH-1:0] div_divisor,
  input  logic                  div_busy,
  input  logic                  div_complete,
  input  logic [DATA_WIDTH-1:0] div_quotient,
  input  logic [DATA_WIDTH-1:0] div_remainder,
  output logic                  wdog_err
);
  localparam int CW = $clog2(WDOG_CYCLES + 1);

  logic [1:0]            r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_dividend, r_divisor;
  logic                  r_signed;
  logic [CW-1:0]         r_wdog_cnt;
  logic                  r_wdog_err;

  logic w_bypass, w_req_ok, w_launch, w_bypass_cmt, w_div_cmt;
  logic w_cmp, w_wdog_hit, w_mt_ok, w_stall;

`ifdef DIV_ZERO_BYPASS_EN
  assign w_bypass = (ex_rt == '0);
`else
  assign w_bypass = 1'b0;
`endif

  assign w_req_ok     = ex_div_req & ~ex_flush;
  assign w_launch     = (r_state == ST_IDLE) & w_req_ok & ~w_bypass & ~div_busy;
  assign w_bypass_cmt = (r_state == ST_IDLE) & w_req_ok & w_bypass;
  assign w_cmp        = div_complete & ((r_state == ST_WAIT) | (r_state == ST_DRAIN));
  // A flush arriving with the completion still kills the result.
  assign w_div_cmt    = (r_state == ST_WAIT) & div_complete & ~ex_flush;
  assign w_wdog_hit   = (r_state != ST_IDLE) & ((r_wdog_cnt + CW'(1)) == CW'(WDOG_CYCLES));
  assign w_mt_ok      = ((r_state == ST_IDLE) | (r_state == ST_DRAIN)) & ~ex_flush;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_launch) w_state_nxt = ST_ISSUE;
      ST_ISSUE: w_state_nxt = ex_flush ? ST_DRAIN : ST_WAIT;
      ST_WAIT:  if (div_complete) w_state_nxt = ST_IDLE;
                else if (ex_flush) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (div_complete) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
    if (w_wdog_hit && !w_cmp) w_state_nxt = ST_IDLE;
  end

  // Anything younger than an in-flight DIV waits; the DIV itself holds EX too.
  always_comb begin
    w_stall = 1'b0;
    case (r_state)
      ST_IDLE:  w_stall = w_req_ok;
      ST_ISSUE: w_stall = 1'b1;
      ST_WAIT:  w_stall = 1'b1;
      ST_DRAIN: w_stall = w_req_ok;
      default:  w_stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_signed   <= 1'b0;
      r_wdog_cnt <= '0;
      r_wdog_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_launch) begin
        r_dividend <= ex_rs;
        r_divisor  <= ex_rt;
        r_signed   <= ex_div_signed;
      end
      // Counter is zero while the start pulse is out, so it counts cycles since start.
      if (w_launch)                r_wdog_cnt <= '0;
      else if (r_state != ST_IDLE) r_wdog_cnt <= r_wdog_cnt + CW'(1);
      if (w_wdog_hit && !w_cmp) r_wdog_err <= 1'b1;
    end
  end

  hilo_regfile #(.DATA_WIDTH(DATA_WIDTH)) u_hilo (
    .clk       (clk),
    .rst       (rst),
    .i_mthi    (ex_mthi & w_mt_ok),
    .i_mtlo    (ex_mtlo & w_mt_ok),
    .i_mt_data (ex_rs),
    .i_cmt_en  (w_div_cmt | w_bypass_cmt),
    .i_cmt_hi  (w_bypass_cmt ? ex_rs : div_remainder),
    .i_cmt_lo  (w_bypass_cmt ? {DATA_WIDTH{1'b1}} : div_quotient),
    .o_hi      (hi),
    .o_lo      (lo)
  );

  assign ex_stall     = w_stall;
  assign div_start    = (r_state == ST_ISSUE);
  assign div_signed_o = r_signed;
  assign div_dividend = r_dividend;
  assign div_divisor  = r_divisor;
  assign wdog_err     = r_wdog_err;
endmodule

// File: tb/tb_div_hilo_ctrl.sv
// Directed bench for div_hilo_ctrl; the divider is played by hand-driven stimulus.
module tb_div_hilo_ctrl;
  logic        clk = 1'b0, rst;
  logic        ex_div_req, ex_div_signed, ex_mthi, ex_mtlo, ex_mfhilo, ex_flush;
  logic [31:0] ex_rs, ex_rt;
  logic        ex_stall, div_start, div_signed_o, div_busy, div_complete, wdog_err;
  logic [31:0] hi, lo, div_dividend, div_divisor, div_quotient, div_remainder;

  int n_pass = 0, n_total = 0, n_start = 0;

  div_hilo_ctrl dut (
    .clk(clk), .rst(rst),
    .ex_div_req(ex_div_req), .ex_div_signed(ex_div_signed), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_mthi(ex_mthi), .ex_mtlo(ex_mtlo), .ex_mfhilo(ex_mfhilo), .ex_flush(ex_flush),
    .ex_stall(ex_stall), .hi(hi), .lo(lo),
    .div_start(div_start), .div_signed_o(div_signed_o),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_busy(div_busy), .div_complete(div_complete),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .wdog_err(wdog_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (div_start) n_start <= n_start + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Present a DIV, check the accept stall, then the ISSUE cycle outputs.
  task automatic launch(input logic sgn, input logic [31:0] rs, input logic [31:0] rt);
    ex_div_req = 1'b1; ex_div_signed = sgn; ex_rs = rs; ex_rt = rt; #1;
    chk("accept_stall", ex_stall, 1);
    tick();
    ex_div_req = 1'b0; div_busy = 1'b1; #1;
    chk("issue_start", div_start, 1);
    chk("issue_signed", div_signed_o, sgn);
    chk("issue_dividend", div_dividend, rs);
    chk("issue_divisor", div_divisor, rt);
  endtask

  task automatic finish(input logic [31:0] q, input logic [31:0] r);
    div_complete = 1'b1; div_quotient = q; div_remainder = r; #1;
    chk("complete_stall", ex_stall, 1);
    tick();
    div_complete = 1'b0; div_busy = 1'b0; #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    ex_div_req = 0; ex_div_signed = 0; ex_rs = 0; ex_rt = 0;
    ex_mthi = 0; ex_mtlo = 0; ex_mfhilo = 0; ex_flush = 0;
    div_busy = 0; div_complete = 0; div_quotient = 0; div_remainder = 0;
    #12;
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_stall", ex_stall, 0);
    chk("rst_start", div_start, 0);
    chk("rst_wdog", wdog_err, 0);
    chk("rst_dividend", div_dividend, 0);
    chk("rst_signed", div_signed_o, 0);
    @(negedge clk) rst = 1'b0;
    tick();

    // DIV -7 / 2
    launch(1'b1, 32'hFFFF_FFF9, 32'd2);
    tick();
    chk("t1_start_once", div_start, 0);
    chk("t1_wait_stall", ex_stall, 1);
    tick(); tick();
    finish(32'hFFFF_FFFD, 32'hFFFF_FFFF);
    chk("t1_lo", lo, 32'hFFFF_FFFD);
    chk("t1_hi", hi, 32'hFFFF_FFFF);
    chk("t1_stall_drop", ex_stall, 0);
    chk("t1_nstart", n_start, 1);

    // DIVU 0xFFFFFFFF / 0x10
    launch(1'b0, 32'hFFFF_FFFF, 32'h10);
    tick();
    chk("t2_signed_wait", div_signed_o, 0);
    tick();
    chk("t2_dividend_stable", div_dividend, 32'hFFFF_FFFF);
    finish(32'h0FFF_FFFF, 32'h0000_000F);
    chk("t2_lo", lo, 32'h0FFF_FFFF);
    chk("t2_hi", hi, 32'h0000_000F);

    // MTHI+MTLO together, then separate prior values 0x11/0x22
    ex_mthi = 1; ex_mtlo = 1; ex_rs = 32'h55; tick();
    chk("mt_both_hi", hi, 32'h55);
    chk("mt_both_lo", lo, 32'h55);
    ex_mtlo = 0; ex_rs = 32'h11; tick();
    ex_mthi = 0; ex_mtlo = 1; ex_rs = 32'h22; tick();
    ex_mtlo = 0;

    // DIV 100/7 flushed in cycle 5 after accept (accept = cycle 0)
    launch(1'b1, 32'd100, 32'd7);
    tick(); tick(); tick(); tick();
    ex_flush = 1; #1;
    chk("fl_flush_cycle_stall", ex_stall, 1);
    tick();
    ex_flush = 0; #1;
    chk("fl_drain_nostall", ex_stall, 0);
    tick();
    ex_div_req = 1; ex_div_signed = 1; ex_rs = 32'd100; ex_rt = 32'd7; #1;
    chk("fl_drain_req_stall", ex_stall, 1);
    tick();
    chk("fl_drain_no_start", div_start, 0);
    div_complete = 1; div_quotient = 32'h99; div_remainder = 32'h88;
    tick();
    div_complete = 0; div_busy = 0; #1;
    chk("fl_hi_kept", hi, 32'h11);
    chk("fl_lo_kept", lo, 32'h22);
    chk("fl_idle_accept_stall", ex_stall, 1);
    tick();
    ex_div_req = 0; div_busy = 1; #1;
    chk("fl_second_start", div_start, 1);
    // MFLO and MTHI both held off while the DIV is in flight
    ex_mfhilo = 1; tick();
    chk("mflo_wait_stall", ex_stall, 1);
    ex_mthi = 1; ex_rs = 32'hDEAD; #1;
    chk("mthi_wait_stall", ex_stall, 1);
    tick();
    ex_mthi = 0;
    finish(32'hE, 32'h2);
    chk("t3_lo", lo, 32'hE);
    chk("t3_hi", hi, 32'h2);
    chk("mflo_released", ex_stall, 0);
    ex_mfhilo = 0;

    // MTHI in IDLE
    ex_mthi = 1; ex_rs = 32'h1234; #1;
    chk("mthi_idle_nostall", ex_stall, 0);
    tick();
    ex_mthi = 0; #1;
    chk("mthi_hi", hi, 32'h1234);
    chk("mthi_lo_kept", lo, 32'hE);

    // Request with flush in IDLE is ignored
    ex_div_req = 1; ex_flush = 1; ex_rs = 32'd9; ex_rt = 32'd3; #1;
    chk("idle_flush_nostall", ex_stall, 0);
    tick();
    ex_div_req = 0; ex_flush = 0; #1;
    chk("idle_flush_nostart", div_start, 0);

    // Stray complete in IDLE is ignored
    div_complete = 1; div_quotient = 32'h1; div_remainder = 32'h2; tick();
    div_complete = 0; #1;
    chk("stray_cmp_hi", hi, 32'h1234);
    chk("stray_cmp_lo", lo, 32'hE);

    // Divide by zero
    ex_div_req = 1; ex_div_signed = 1; ex_rs = 32'd5; ex_rt = 32'd0; #1;
    chk("dz_accept_stall", ex_stall, 1);
    tick();
    ex_div_req = 0; #1;
`ifdef DIV_ZERO_BYPASS_EN
    chk("dz_no_start", div_start, 0);
    chk("dz_stall_one", ex_stall, 0);
`else
    chk("dz_start", div_start, 1);
    div_busy = 1; tick();
    finish(32'hFFFF_FFFF, 32'd5);
`endif
    chk("dz_lo", lo, 32'hFFFF_FFFF);
    chk("dz_hi", hi, 32'd5);

    // Busy divider holds a request in IDLE
    div_busy = 1; ex_div_req = 1; ex_div_signed = 0; ex_rs = 32'h40; ex_rt = 32'h4; #1;
    chk("busy_hold_stall", ex_stall, 1);
    tick();
    chk("busy_hold_nostart", div_start, 0);
    div_busy = 0; #1;
    chk("busy_release_stall", ex_stall, 1);
    tick();
    ex_div_req = 0; div_busy = 1; #1;
    chk("wd_start", div_start, 1);

    // Watchdog: complete never arrives; start cycle is cycle 0
    repeat (47) tick();
    chk("wd_not_yet", wdog_err, 0);
    chk("wd_still_stall", ex_stall, 1);
    tick();
    chk("wd_err", wdog_err, 1);
    chk("wd_idle_nostall", ex_stall, 0);
    chk("wd_hi_kept", hi, 32'd5);
    chk("wd_lo_kept", lo, 32'hFFFF_FFFF);
    div_busy = 0;
    tick();
    chk("wd_sticky", wdog_err, 1);
`ifdef DIV_ZERO_BYPASS_EN
    chk("nstart_total", n_start, 5);
`else
    chk("nstart_total", n_start, 6);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
